// File: rtl/mem_block_copier_if.sv
// Control and single-port memory bus of mem_block_copier; master = the copier, slave = CPU/memory side.
// With MEM_BLOCK_COPIER_CHECKSUM_EN defined the bundle also carries the running checksum.
// No backpressure: the memory port is combinational read, single-cycle write.
interface mem_block_copier_if #(
    parameter int LEN_W = 10
);
    logic             start;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic             mem_write;
    logic [31:0]      mem_address;
    logic [31:0]      mem_write_data;
    logic [31:0]      mem_read_data;
`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
    logic [31:0]      checksum;

    modport master (
        input  start, src_addr, dst_addr, len, mem_read_data,
        output busy, done, mem_write, mem_address, mem_write_data, checksum
    );
    modport slave (
        output start, src_addr, dst_addr, len, mem_read_data,
        input  busy, done, mem_write, mem_address, mem_write_data, checksum
    );
`else
    modport master (
        input  start, src_addr, dst_addr, len, mem_read_data,
        output busy, done, mem_write, mem_address, mem_write_data
    );
    modport slave (
        output start, src_addr, dst_addr, len, mem_read_data,
        input  busy, done, mem_write, mem_address, mem_write_data
    );
`endif
endinterface

// File: rtl/mem_block_copier.sv
// Word block copier owning the data-memory port while busy; optional checksum via MEM_BLOCK_COPIER_CHECKSUM_EN.
// Latency: 2 cycles per word (READ, WRITE) plus one DONE cycle; len=0 goes straight to DONE.
// No backpressure: start is sampled only in IDLE and ignored otherwise; memory is assumed always ready.
module mem_block_copier #(
    parameter int LEN_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_block_copier_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [31:0]      buf_q, buf_d;
    logic [LEN_W-1:0] rem_q, rem_d;
`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
    logic [31:0]      csum_q, csum_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            buf_q   <= '0;
            rem_q   <= '0;
`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            buf_q   <= buf_d;
            rem_q   <= rem_d;
`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        buf_d   = buf_q;
        rem_d   = rem_q;
`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    src_d = bus.src_addr & ~32'd3;
                    dst_d = bus.dst_addr & ~32'd3;
                    rem_d = bus.len;
`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
                    csum_d = '0;
`endif
                    state_d = (bus.len != '0) ? ST_READ : ST_DONE;
                end
            end
            ST_READ: begin
                buf_d   = bus.mem_read_data;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                // Pointers wrap modulo 2^32; overlapping regions replicate by design.
                src_d = src_q + 32'd4;
                dst_d = dst_q + 32'd4;
                rem_d = rem_q - 1'b1;
`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
                csum_d = csum_q + buf_q;
`endif
                state_d = (rem_q == LEN_W'(1)) ? ST_DONE : ST_READ;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs come from state and registers only, so reset kills mem_write at once.
    always_comb begin
        bus.busy           = 1'b0;
        bus.done           = 1'b0;
        bus.mem_write      = 1'b0;
        bus.mem_address    = '0;
        bus.mem_write_data = '0;
        case (state_q)
            ST_READ: begin
                bus.busy        = 1'b1;
                bus.mem_address = src_q;
            end
            ST_WRITE: begin
                bus.busy           = 1'b1;
                bus.mem_write      = 1'b1;
                bus.mem_address    = dst_q;
                bus.mem_write_data = buf_q;
            end
            ST_DONE: begin
                bus.done = 1'b1;
            end
            default: begin
                bus.busy = 1'b0;
            end
        endcase
    end

`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
    assign bus.checksum = csum_q;
`endif

endmodule

// File: doc/mem_block_copier.md
Name: mem_block_copier

Overview:
- Initiator/master side of the single-port word memory interface (write, address, write_data, read_data with combinational read).
- Copies a block of len 32-bit words from src_addr to dst_addr in the data memory using a small read/write state machine. Two cycles per word.
- Sits beside the CPU datapath and owns the memory port while busy. Arbitration with the CPU is external and outside this block.

Parameters:
- LEN_W, 10, width of the len input; the maximum block is 2^LEN_W-1 words.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  copy request; sampled only in IDLE
- src_addr  input  32  source byte address; bits [1:0] ignored (forced 0)
- dst_addr  input  32  destination byte address; bits [1:0] ignored (forced 0)
- len  input  LEN_W  number of words to copy
- busy  output  1  high in READ and WRITE states
- done  output  1  one-cycle pulse when the copy completes
- mem_write  output  1  memory write enable
- mem_address  output  32  memory word address (bits [1:0] always 0)
- mem_write_data  output  32  memory write data
- mem_read_data  input  32  combinational memory read data

Behaviour:
- Reset is asynchronous and active-low, on rst_n; single clock clk.
- While rst_n=0: state=IDLE; internal src/dst pointers, remaining count and data buffer = 0.
  - Outputs: busy=0, done=0, mem_write=0, mem_address=0, mem_write_data=0.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - On an edge with start=1, latch src_addr&~3, dst_addr&~3 and len.
  - If len!=0, go to READ; if len=0, go to DONE with no memory access.
  - mem_address=0, mem_write=0.
- READ (1 cycle):
  - mem_address=src pointer, mem_write=0.
  - At the edge, capture mem_read_data into the buffer and go to WRITE.
- WRITE (1 cycle):
  - mem_address=dst pointer, mem_write_data=buffer, mem_write=1.
  - At the edge: the memory commits the word, src+=4, dst+=4, remaining-=1.
  - If remaining was 1, go to DONE; otherwise go to READ.
- DONE (1 cycle): done=1, busy=0, mem_write=0. Then go to IDLE. start is ignored in DONE.
- mem_write, mem_address, mem_write_data and busy are decoded from state and registers only, with no combinational path from inputs.
- Latency: with start sampled at edge E0 and len=N>0, done is high during the cycle after edge E0+2N. The total is 2N+1 cycles from start to done.
- len=0: done is high in the cycle after the start edge; there are zero writes.
- Start while busy or in DONE: ignored. The in-flight parameters are unchanged.
- Pointer arithmetic is modulo 2^32; crossing 0xFFFFFFFC wraps to 0x00000000 without error.
- Overlapping regions: strict ascending word-by-word copy. If dst is in (src, src+4N), already-copied words are re-read, which replicates the pattern. This is defined behaviour, not an error.
- Inputs src_addr/dst_addr/len may change freely after the start edge.
- Reset mid-copy: mem_write drops immediately (asynchronously). Words already written remain; no done pulse is produced.

Optional Feature:
- Macro: MEM_BLOCK_COPIER_CHECKSUM_EN.
- Defined:
  - Adds output checksum [31:0]. It is cleared to 0 on an accepted start and on reset.
  - Each WRITE edge adds the buffer word, modulo 2^32.
  - It holds its value after done until the next accepted start.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Preload mem[0x100..0x108]=0x11,0x22,0x33; start src=0x100 dst=0x200 len=3.
  - Required: mem[0x200..0x208]=0x11,0x22,0x33.
  - busy is high for 6 cycles; done pulses exactly once, 7 cycles after the start edge; mem_write pulses exactly 3 times.
- start with len=0 -> done in the next cycle, busy never high, no mem_write; memory unchanged.
- Copy len=4 and pulse start again with len=1 at the 2nd WRITE cycle.
  - Required: the second start is ignored; exactly 4 words are copied; one done pulse.
- src=0x103 dst=0x206 len=1 -> mem_address is 0x100 in READ and 0x204 in WRITE.
- Overlap: mem[0x0]=0xA, mem[0x4]=0xB; copy src=0x0 dst=0x4 len=2 -> mem[0x4]=0xA, mem[0x8]=0xA.
- Assert rst_n=0 mid-WRITE of a len=5 copy.
  - Required: mem_write=0 immediately, state IDLE, no done pulse.
  - A new start after release works normally.
  - With MEM_BLOCK_COPIER_CHECKSUM_EN defined, the first test gives checksum=0x66.
